// File: rtl/mrv1_mem_arbiter.sv
// mrv1_mem_arbiter: shares one memory request channel between imem and dmem.
// Round-robin grant, locked while stalled; in-order response steering.
module mrv1_mem_arbiter #(
    parameter int ADDR_WIDTH_P      = 32,
    parameter int DATA_WIDTH_P      = 32,
    parameter int IMEM_TAG_WIDTH_P  = 3,
    parameter int MAX_OUTSTANDING_P = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic                          imem_req_vld_i,
    output logic                          imem_req_rdy_o,
    input  logic [ADDR_WIDTH_P-1:0]       imem_req_addr_i,
    input  logic [IMEM_TAG_WIDTH_P-1:0]   imem_req_tag_i,
    output logic                          imem_resp_vld_o,
    output logic [DATA_WIDTH_P-1:0]       imem_resp_data_o,
    output logic [IMEM_TAG_WIDTH_P-1:0]   imem_resp_tag_o,

    input  logic                          dmem_req_vld_i,
    output logic                          dmem_req_rdy_o,
    input  logic [ADDR_WIDTH_P-1:0]       dmem_req_addr_i,
    input  logic                          dmem_req_w_en_i,
    input  logic [DATA_WIDTH_P/8-1:0]     dmem_req_w_be_i,
    input  logic [DATA_WIDTH_P-1:0]       dmem_req_w_data_i,
    output logic                          dmem_resp_vld_o,
    output logic [DATA_WIDTH_P-1:0]       dmem_resp_r_data_o,
    output logic                          dmem_resp_err_o,

    output logic                          mem_req_vld_o,
    input  logic                          mem_req_rdy_i,
    output logic [ADDR_WIDTH_P-1:0]       mem_req_addr_o,
    output logic                          mem_req_w_en_o,
    output logic [DATA_WIDTH_P/8-1:0]     mem_req_w_be_o,
    output logic [DATA_WIDTH_P-1:0]       mem_req_w_data_o,
    input  logic                          mem_resp_vld_i,
    input  logic [DATA_WIDTH_P-1:0]       mem_resp_data_i,
    input  logic                          mem_resp_err_i,

    output logic                          unexp_resp_o
);

    localparam int PTR_W = (MAX_OUTSTANDING_P > 1) ? $clog2(MAX_OUTSTANDING_P) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING_P + 1);
    localparam int BE_W  = DATA_WIDTH_P / 8;

    localparam logic SRC_IMEM = 1'b0;
    localparam logic SRC_DMEM = 1'b1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING_P - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING_P);

    logic                        fifo_src_q [MAX_OUTSTANDING_P];
    logic [IMEM_TAG_WIDTH_P-1:0] fifo_tag_q [MAX_OUTSTANDING_P];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             lock_q;
    logic             lock_src_q;
    logic             last_grant_q;
    logic             unexp_q;

    logic sel_src;
    logic sel_vld;
    logic full;
    logic empty;
    logic req_ok;
    logic push;
    logic pop;
    logic head_src;

    logic [IMEM_TAG_WIDTH_P-1:0] head_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Pick the granted port: locked port, else alternate on contention
    always_comb begin
        sel_src = SRC_IMEM;
        if (lock_q) begin
            sel_src = lock_src_q;
        end else if (imem_req_vld_i && dmem_req_vld_i) begin
            sel_src = ~last_grant_q;
        end else if (dmem_req_vld_i) begin
            sel_src = SRC_DMEM;
        end
    end

    assign sel_vld = (sel_src == SRC_DMEM) ? dmem_req_vld_i : imem_req_vld_i;

    assign req_ok         = rst_ni & mem_req_rdy_i & ~full;
    assign mem_req_vld_o  = rst_ni & sel_vld & ~full;
    assign imem_req_rdy_o = req_ok & (sel_src == SRC_IMEM);
    assign dmem_req_rdy_o = req_ok & (sel_src == SRC_DMEM);
    assign push           = mem_req_vld_o & mem_req_rdy_i;

    // Route the granted port's fields to memory; imem never writes
    always_comb begin
        mem_req_addr_o   = imem_req_addr_i;
        mem_req_w_en_o   = 1'b0;
        mem_req_w_be_o   = '0;
        mem_req_w_data_o = '0;
        if (sel_src == SRC_DMEM) begin
            mem_req_addr_o   = dmem_req_addr_i;
            mem_req_w_en_o   = dmem_req_w_en_i;
            mem_req_w_be_o   = BE_W'(dmem_req_w_be_i);
            mem_req_w_data_o = dmem_req_w_data_i;
        end
    end

    assign head_src = fifo_src_q[rd_ptr_q];
    assign head_tag = fifo_tag_q[rd_ptr_q];
    assign pop      = mem_resp_vld_i & ~empty;

    assign imem_resp_vld_o    = pop & (head_src == SRC_IMEM);
    assign imem_resp_data_o   = imem_resp_vld_o ? mem_resp_data_i : '0;
    assign imem_resp_tag_o    = imem_resp_vld_o ? head_tag : '0;
    assign dmem_resp_vld_o    = pop & (head_src == SRC_DMEM);
    assign dmem_resp_r_data_o = dmem_resp_vld_o ? mem_resp_data_i : '0;
    assign dmem_resp_err_o    = dmem_resp_vld_o & mem_resp_err_i;
    assign unexp_resp_o       = unexp_q;

    // Record originator and tag of each accepted request
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_src_q[wr_ptr_q] <= sel_src;
            fifo_tag_q[wr_ptr_q] <= imem_req_tag_i;
        end
    end

    // Pointers, occupancy, grant history, lock and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_src_q   <= SRC_IMEM;
            last_grant_q <= SRC_DMEM;
            unexp_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q     <= ptr_inc(wr_ptr_q);
                last_grant_q <= sel_src;
                lock_q       <= 1'b0;
            end else if (mem_req_vld_o) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel_src;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (mem_resp_vld_i && empty) begin
                unexp_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mrv1_mem_arbiter.sv
// tb_mrv1_mem_arbiter: random requesters and memory against a queue model.
// Grant order and response routing are predicted from arbitration rules.
module tb_mrv1_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TW   = 3;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          imem_req_vld_i, imem_req_rdy_o;
    logic [AW-1:0] imem_req_addr_i;
    logic [TW-1:0] imem_req_tag_i;
    logic          imem_resp_vld_o;
    logic [DW-1:0] imem_resp_data_o;
    logic [TW-1:0] imem_resp_tag_o;
    logic          dmem_req_vld_i, dmem_req_rdy_o;
    logic [AW-1:0] dmem_req_addr_i;
    logic          dmem_req_w_en_i;
    logic [3:0]    dmem_req_w_be_i;
    logic [DW-1:0] dmem_req_w_data_i;
    logic          dmem_resp_vld_o;
    logic [DW-1:0] dmem_resp_r_data_o;
    logic          dmem_resp_err_o;
    logic          mem_req_vld_o, mem_req_rdy_i;
    logic [AW-1:0] mem_req_addr_o;
    logic          mem_req_w_en_o;
    logic [3:0]    mem_req_w_be_o;
    logic [DW-1:0] mem_req_w_data_o;
    logic          mem_resp_vld_i;
    logic [DW-1:0] mem_resp_data_i;
    logic          mem_resp_err_i;
    logic          unexp_resp_o;

    always #5 clk = ~clk;

    mrv1_mem_arbiter #(
        .ADDR_WIDTH_P(AW), .DATA_WIDTH_P(DW),
        .IMEM_TAG_WIDTH_P(TW), .MAX_OUTSTANDING_P(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .imem_req_vld_i(imem_req_vld_i), .imem_req_rdy_o(imem_req_rdy_o),
        .imem_req_addr_i(imem_req_addr_i), .imem_req_tag_i(imem_req_tag_i),
        .imem_resp_vld_o(imem_resp_vld_o), .imem_resp_data_o(imem_resp_data_o),
        .imem_resp_tag_o(imem_resp_tag_o),
        .dmem_req_vld_i(dmem_req_vld_i), .dmem_req_rdy_o(dmem_req_rdy_o),
        .dmem_req_addr_i(dmem_req_addr_i), .dmem_req_w_en_i(dmem_req_w_en_i),
        .dmem_req_w_be_i(dmem_req_w_be_i), .dmem_req_w_data_i(dmem_req_w_data_i),
        .dmem_resp_vld_o(dmem_resp_vld_o), .dmem_resp_r_data_o(dmem_resp_r_data_o),
        .dmem_resp_err_o(dmem_resp_err_o),
        .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_w_en_o(mem_req_w_en_o),
        .mem_req_w_be_o(mem_req_w_be_o), .mem_req_w_data_o(mem_req_w_data_o),
        .mem_resp_vld_i(mem_resp_vld_i), .mem_resp_data_i(mem_resp_data_i),
        .mem_resp_err_i(mem_resp_err_i),
        .unexp_resp_o(unexp_resp_o)
    );

    typedef struct packed {
        logic          src;
        logic [TW-1:0] tag;
    } ent_t;

    ent_t m_q[$];
    int   m_last;
    int   m_lock;
    bit   m_unexp;

    bit            i_pend, d_pend;
    logic [AW-1:0] i_addr, d_addr;
    logic [TW-1:0] i_tag;
    logic          d_we;
    logic [3:0]    d_be;
    logic [DW-1:0] d_wd;

    int p_i, p_d, p_rdy, p_resp;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        i_pend = 0;
        d_pend = 0;
        imem_req_vld_i    = 0;
        imem_req_addr_i   = '0;
        imem_req_tag_i    = '0;
        dmem_req_vld_i    = 0;
        dmem_req_addr_i   = '0;
        dmem_req_w_en_i   = 0;
        dmem_req_w_be_i   = '0;
        dmem_req_w_data_i = '0;
        mem_req_rdy_i     = 0;
        mem_resp_vld_i    = 0;
        mem_resp_data_i   = '0;
        mem_resp_err_i    = 0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = 1;
        m_lock  = -1;
        m_unexp = 0;
    endtask

    task automatic step();
        int   win;
        bit   full, go;
        ent_t h, e;
        @(posedge clk);
        #1;
        if (!i_pend && $urandom_range(0, 99) < p_i) begin
            i_pend = 1;
            i_addr = AW'($urandom) & ~AW'(3);
            i_tag  = TW'($urandom);
        end
        if (!d_pend && $urandom_range(0, 99) < p_d) begin
            d_pend = 1;
            d_addr = AW'($urandom);
            d_we   = 1'($urandom_range(0, 1));
            d_be   = 4'($urandom);
            d_wd   = DW'($urandom);
        end
        imem_req_vld_i    = i_pend;
        imem_req_addr_i   = i_addr;
        imem_req_tag_i    = i_tag;
        dmem_req_vld_i    = d_pend;
        dmem_req_addr_i   = d_addr;
        dmem_req_w_en_i   = d_we;
        dmem_req_w_be_i   = d_be;
        dmem_req_w_data_i = d_wd;
        mem_req_rdy_i     = ($urandom_range(0, 99) < p_rdy);
        mem_resp_vld_i    = (m_q.size() > 0) && ($urandom_range(0, 99) < p_resp);
        mem_resp_data_i   = DW'($urandom);
        mem_resp_err_i    = 1'($urandom_range(0, 1));
        #3;
        full = (m_q.size() == MAXO);
        if (m_lock >= 0) win = m_lock;
        else if (i_pend && d_pend) win = (m_last == 0) ? 1 : 0;
        else if (i_pend) win = 0;
        else if (d_pend) win = 1;
        else win = -1;
        go = ((win == 0 && i_pend) || (win == 1 && d_pend)) && !full;
        chk("mem_vld", mem_req_vld_o, go);
        if (go && win == 0) begin
            chk("i_addr", mem_req_addr_o, i_addr);
            chk("i_wen", mem_req_w_en_o, 0);
            chk("i_be", mem_req_w_be_o, 0);
        end
        if (go && win == 1) begin
            chk("d_addr", mem_req_addr_o, d_addr);
            chk("d_wen", mem_req_w_en_o, d_we);
            chk("d_be", mem_req_w_be_o, d_be);
            chk("d_wdata", mem_req_w_data_o, d_wd);
        end
        if (i_pend) chk("i_rdy", imem_req_rdy_o, go && win == 0 && mem_req_rdy_i);
        if (d_pend) chk("d_rdy", dmem_req_rdy_o, go && win == 1 && mem_req_rdy_i);
        chk("unexp", unexp_resp_o, m_unexp);
        if (mem_resp_vld_i && m_q.size() > 0) begin
            h = m_q.pop_front();
            chk("i_rvld", imem_resp_vld_o, h.src == 0);
            chk("d_rvld", dmem_resp_vld_o, h.src == 1);
            if (h.src == 0) begin
                chk("i_rdata", imem_resp_data_o, mem_resp_data_i);
                chk("i_rtag", imem_resp_tag_o, h.tag);
            end else begin
                chk("d_rdata", dmem_resp_r_data_o, mem_resp_data_i);
                chk("d_rerr", dmem_resp_err_o, mem_resp_err_i);
            end
        end else begin
            chk("i_rvld_idle", imem_resp_vld_o, 0);
            chk("d_rvld_idle", dmem_resp_vld_o, 0);
            chk("d_rdata_idle", dmem_resp_r_data_o, 0);
            if (mem_resp_vld_i) m_unexp = 1;
        end
        if (go && mem_req_rdy_i) begin
            e.src = (win == 1);
            e.tag = i_tag;
            m_q.push_back(e);
            m_last = win;
            m_lock = -1;
            if (win == 0) i_pend = 0;
            else d_pend = 0;
        end else if (go) begin
            m_lock = win;
        end
    endtask

    task automatic phase(input int pi, input int pd, input int pr,
                         input int ps, input int n);
        p_i = pi;
        p_d = pd;
        p_rdy = pr;
        p_resp = ps;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_ni = 0;
        clear_inputs();
        model_reset();
        #3;
        chk("rst_mem_vld", mem_req_vld_o, 0);
        chk("rst_i_rdy", imem_req_rdy_o, 0);
        chk("rst_d_rdy", dmem_req_rdy_o, 0);
        chk("rst_i_rvld", imem_resp_vld_o, 0);
        chk("rst_d_rvld", dmem_resp_vld_o, 0);
        chk("rst_unexp", unexp_resp_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;

        phase(100, 0, 100, 60, 30);
        phase(100, 100, 100, 100, 30);
        phase(100, 100, 30, 50, 100);
        phase(100, 100, 100, 0, 10);
        phase(100, 100, 100, 100, 10);
        phase(50, 50, 50, 50, 2000);
        phase(0, 0, 100, 100, 20);
        phase(100, 100, 100, 0, 3);

        rst_ni = 0;
        #1;
        chk("arst_mem_vld", mem_req_vld_o, 0);
        chk("arst_i_rdy", imem_req_rdy_o, 0);
        chk("arst_d_rdy", dmem_req_rdy_o, 0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1 rst_ni = 1;
        #3 chk("post_rst_unexp", unexp_resp_o, 0);
        @(posedge clk);
        #1 mem_resp_vld_i = 1;
        #3;
        chk("stale_i_rvld", imem_resp_vld_o, 0);
        chk("stale_d_rvld", dmem_resp_vld_o, 0);
        @(posedge clk);
        #1 mem_resp_vld_i = 0;
        m_unexp = 1;
        for (int k = 0; k < 3; k++) begin
            #3 chk("unexp_sticky", unexp_resp_o, 1);
            @(posedge clk);
            #1;
        end
        phase(50, 50, 70, 50, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mrv1_mem_arbiter.md
Name: mrv1_mem_arbiter

Overview:
Shares one single-port TCM/memory request channel between the core's instruction fetch (imem) and load/store (dmem) interfaces. Arbitration is round-robin, with the grant locked while a request is stalled. Responses come back from memory in request order and are steered back to the originator. An in-order outstanding-request FIFO records, per request, which port issued it and the imem tag. The block sits between mrv1_core and the memory model/TCM.

Parameters:
ADDR_WIDTH_P, 32, request address width
DATA_WIDTH_P, 32, read/write data width; byte enables are DATA_WIDTH_P/8
IMEM_TAG_WIDTH_P, 3, imem tag width (log2 of thread count)
MAX_OUTSTANDING_P, 4, outstanding-request FIFO depth; power of 2, >=1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
imem_req_vld_i  in  1  fetch request valid
imem_req_rdy_o  out  1  fetch request accepted
imem_req_addr_i  in  ADDR_WIDTH_P  fetch address
imem_req_tag_i  in  IMEM_TAG_WIDTH_P  fetch tag
imem_resp_vld_o  out  1  fetch response valid
imem_resp_data_o  out  DATA_WIDTH_P  fetched instruction
imem_resp_tag_o  out  IMEM_TAG_WIDTH_P  tag of the returning fetch
dmem_req_vld_i  in  1  data request valid
dmem_req_rdy_o  out  1  data request accepted
dmem_req_addr_i  in  ADDR_WIDTH_P  data address
dmem_req_w_en_i  in  1  1=write, 0=read
dmem_req_w_be_i  in  DATA_WIDTH_P/8  write byte enables
dmem_req_w_data_i  in  DATA_WIDTH_P  write data
dmem_resp_vld_o  out  1  data response valid (reads and write acks)
dmem_resp_r_data_o  out  DATA_WIDTH_P  read data
dmem_resp_err_o  out  1  memory error on this response
mem_req_vld_o  out  1  downstream request valid
mem_req_rdy_i  in  1  downstream request accepted
mem_req_addr_o  out  ADDR_WIDTH_P  downstream address
mem_req_w_en_o  out  1  downstream write enable (0 for imem)
mem_req_w_be_o  out  DATA_WIDTH_P/8  downstream byte enables (0 for imem)
mem_req_w_data_o  out  DATA_WIDTH_P  downstream write data
mem_resp_vld_i  in  1  downstream response valid, one per accepted request, in order
mem_resp_data_i  in  DATA_WIDTH_P  downstream response data
mem_resp_err_i  in  1  downstream response error
unexp_resp_o  out  1  sticky flag: response arrived with FIFO empty

Behaviour:
- Reset (rst_ni low, async): FIFO empty, count=0, lock=0, last_grant=DMEM (so imem wins the first contest), unexp_resp_o=0. All vld/rdy outputs are 0. A request or response in flight during reset is discarded.
- full = (count == MAX_OUTSTANDING_P). While full, mem_req_vld_o=0. No same-cycle push/pop bypass: a pop in the full cycle frees the slot for the next cycle only.
- Selection when lock=0: exactly one valid port wins. If both are valid, the winner is the port not equal to last_grant.
- Selection when lock=1: the locked port holds the grant.
- mem_req_vld_o = selected port valid & ~full. Mem fields are muxed combinationally from the selected port.
- Selected port's req_rdy_o = mem_req_rdy_i & ~full. The other port's rdy=0.
- Handshake (mem_req_vld_o & mem_req_rdy_i):
  - push {src, imem_tag} into the FIFO;
  - last_grant <= src;
  - lock <= 0.
- vld & ~rdy: lock <= 1. The grant stays on the same port until it is accepted, so mem fields stay stable (requesters hold their fields per vld/rdy rules).
- Response (mem_resp_vld_i) with FIFO non-empty: pop the head in the same cycle. Outputs are combinational, 0-cycle latency:
  - head src=IMEM: imem_resp_vld_o=1, imem_resp_data_o=mem_resp_data_i, imem_resp_tag_o=head tag;
  - head src=DMEM: dmem_resp_vld_o=1, dmem_resp_r_data_o=mem_resp_data_i, dmem_resp_err_o=mem_resp_err_i.
  - An err on an imem response is dropped.
- Response with FIFO empty: no output valid asserted, unexp_resp_o <= 1 until reset.
- Simultaneous push and pop: count unchanged, pointers both advance and wrap modulo MAX_OUTSTANDING_P.
- Throughput: 1 request/cycle and 1 response/cycle sustained.

Test Plan:
- Reset, imem-only stream of addrs 0x0,0x4,0x8 with tags 1,2,3; mem_req_rdy_i=1; responses 2 cycles later with data 0xA,0xB,0xC -> imem_resp_tag_o sequence 1,2,3 carrying 0xA,0xB,0xC; dmem outputs stay 0.
- Both ports valid every cycle, rdy=1 -> grants alternate IMEM,DMEM,IMEM,DMEM starting with IMEM after reset; a dmem write (addr 0x100, be 4'hF, data 0xDEADBEEF) appears unchanged on mem_req_*.
- Dmem read valid, mem_req_rdy_i=0 for 3 cycles while imem also valid -> mem_req_addr_o holds the dmem addr for all 3 cycles; imem_req_rdy_o=0; dmem_req_rdy_o pulses when rdy rises.
- MAX_OUTSTANDING_P=4, 4 accepted requests, no responses -> 5th request sees mem_req_vld_o=0; one response frees one slot -> request accepted the next cycle.
- Dmem read response with mem_resp_err_i=1 -> dmem_resp_err_o=1 in the same cycle; response with FIFO empty -> unexp_resp_o=1 and stays high.
- Assert rst_ni low with 2 requests outstanding -> count=0 immediately; later responses set unexp_resp_o after reset release.
